// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache between the fetch unit and the memory controller.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module inst_cache #(
  parameter int INDEX_WIDTH = 8,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic                  IF_inst_read_valid,
  input  logic [ADDR_WIDTH-1:0] IF_inst_addr,
  output logic                  IF_inst_valid,
  output logic [31:0]           IF_inst,
  output logic                  MemCtrl_read_valid,
  output logic [ADDR_WIDTH-1:0] MemCtrl_addr,
  input  logic                  MemCtrl_inst_valid,
  input  logic [31:0]           MemCtrl_inst
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    MISS_WAIT = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    kill_q, kill_d;
  logic                    if_valid_q, if_valid_d;
  logic [31:0]             if_inst_q, if_inst_d;
  logic                    mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [LINES-1:0]        valid_q;
  logic [31:0]             data_q [LINES];
  logic [TAG_WIDTH-1:0]    tag_q  [LINES];

  logic [INDEX_WIDTH-1:0]  lookup_idx_s;
  logic [TAG_WIDTH-1:0]    lookup_tag_s;
  logic                    hit_s;
  logic [INDEX_WIDTH-1:0]  fill_idx_s;
  logic [TAG_WIDTH-1:0]    fill_tag_s;
  logic                    fill_we_s;
  logic                    hit_evt_s;
  logic                    miss_evt_s;
  logic                    unused_addr_s;

  assign lookup_idx_s  = IF_inst_addr[INDEX_WIDTH+1:2];
  assign lookup_tag_s  = IF_inst_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign hit_s         = valid_q[lookup_idx_s] && (tag_q[lookup_idx_s] == lookup_tag_s);
  assign fill_idx_s    = req_addr_q[INDEX_WIDTH+1:2];
  assign fill_tag_s    = req_addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign unused_addr_s = ^IF_inst_addr[1:0];

  // Next-state and output logic for the lookup/fill sequencer.
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    if_valid_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_valid_d = mem_valid_q;
    req_addr_d  = req_addr_q;
    fill_we_s   = 1'b0;
    hit_evt_s   = 1'b0;
    miss_evt_s  = 1'b0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        // Skipping the cycle after a pulse keeps a held request from answering twice.
        if (IF_inst_read_valid && !if_valid_q && !clear) begin
          if (hit_s) begin
            if_valid_d = 1'b1;
            if_inst_d  = data_q[lookup_idx_s];
            hit_evt_s  = 1'b1;
          end else begin
            req_addr_d  = {IF_inst_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_valid_d = 1'b1;
            miss_evt_s  = 1'b1;
            state_d     = MISS_WAIT;
          end
        end else begin
          if_valid_d = 1'b0;
        end
      end
      MISS_WAIT: begin
        if (MemCtrl_inst_valid) begin
          mem_valid_d = 1'b0;
          fill_we_s   = 1'b1;
          kill_d      = 1'b0;
          state_d     = IDLE;
          if (!kill_q && !clear) begin
            if_valid_d = 1'b1;
            if_inst_d  = MemCtrl_inst;
          end else begin
            if_valid_d = 1'b0;
          end
        end else if (clear) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        kill_d      = 1'b0;
      end
    endcase
  end

  // Control and output registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      if_valid_q  <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_valid_q <= 1'b0;
      req_addr_q  <= {ADDR_WIDTH{1'b0}};
      valid_q     <= {LINES{1'b0}};
    end else if (rdy) begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      if_valid_q  <= if_valid_d;
      if_inst_q   <= if_inst_d;
      mem_valid_q <= mem_valid_d;
      req_addr_q  <= req_addr_d;
      if (fill_we_s) begin
        valid_q[fill_idx_s] <= 1'b1;
      end
    end
  end

  // Line storage; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we_s) begin
      data_q[fill_idx_s] <= MemCtrl_inst;
      tag_q[fill_idx_s]  <= fill_tag_s;
    end
  end

  assign IF_inst_valid      = if_valid_q;
  assign IF_inst            = if_inst_q;
  assign MemCtrl_read_valid = mem_valid_q;
  assign MemCtrl_addr       = req_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Free-running statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else if (rdy) begin
      if (hit_evt_s) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss_evt_s) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = hit_evt_s ^ miss_evt_s;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        IF_inst_read_valid;
  logic [31:0] IF_inst_addr;
  logic        IF_inst_valid;
  logic [31:0] IF_inst;
  logic        MemCtrl_read_valid;
  logic [31:0] MemCtrl_addr;
  logic        MemCtrl_inst_valid;
  logic [31:0] MemCtrl_inst;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks_cnt = 0;
  int fail_cnt   = 0;

  inst_cache dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .clear              (clear),
    .IF_inst_read_valid (IF_inst_read_valid),
    .IF_inst_addr       (IF_inst_addr),
    .IF_inst_valid      (IF_inst_valid),
    .IF_inst            (IF_inst),
    .MemCtrl_read_valid (MemCtrl_read_valid),
    .MemCtrl_addr       (MemCtrl_addr),
    .MemCtrl_inst_valid (MemCtrl_inst_valid),
    .MemCtrl_inst       (MemCtrl_inst)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count          (hit_count),
    .miss_count         (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a line that is expected to miss; memory answers lat cycles after the request edge.
  task automatic miss_fill(input logic [31:0] a, input logic [31:0] d, input int lat, input bit expect_resp);
    IF_inst_read_valid = 1'b1;
    IF_inst_addr       = a;
    tick();
    check("miss_req", {31'd0, MemCtrl_read_valid}, 32'd1);
    check("miss_addr", MemCtrl_addr, {a[31:2], 2'b00});
    check("miss_noresp", {31'd0, IF_inst_valid}, 32'd0);
    IF_inst_read_valid = 1'b0;
    for (int i = 0; i < lat - 1; i++) begin
      tick();
      check("wait_req", {31'd0, MemCtrl_read_valid}, 32'd1);
      check("wait_addr", MemCtrl_addr, {a[31:2], 2'b00});
    end
    MemCtrl_inst_valid = 1'b1;
    MemCtrl_inst       = d;
    tick();
    MemCtrl_inst_valid = 1'b0;
    check("fill_req_drop", {31'd0, MemCtrl_read_valid}, 32'd0);
    check("fill_resp", {31'd0, IF_inst_valid}, {31'd0, expect_resp});
    if (expect_resp) begin
      check("fill_data", IF_inst, d);
    end
    tick();
    check("fill_pulse_end", {31'd0, IF_inst_valid}, 32'd0);
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] d);
    IF_inst_read_valid = 1'b1;
    IF_inst_addr       = a;
    tick();
    check("hit_resp", {31'd0, IF_inst_valid}, 32'd1);
    check("hit_data", IF_inst, d);
    check("hit_nomem", {31'd0, MemCtrl_read_valid}, 32'd0);
    IF_inst_read_valid = 1'b0;
    tick();
    check("hit_pulse_end", {31'd0, IF_inst_valid}, 32'd0);
  endtask

  initial begin
    logic [5:0] pattern;
    rst = 1'b1;
    rdy = 1'b1;
    clear = 1'b0;
    IF_inst_read_valid = 1'b0;
    IF_inst_addr = 32'd0;
    MemCtrl_inst_valid = 1'b0;
    MemCtrl_inst = 32'd0;
    tick();
    tick();
    check("rst_if_valid", {31'd0, IF_inst_valid}, 32'd0);
    check("rst_if_inst", IF_inst, 32'd0);
    check("rst_mem_valid", {31'd0, MemCtrl_read_valid}, 32'd0);
    check("rst_mem_addr", MemCtrl_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss then hit.
    miss_fill(32'h0000_0000, 32'h0000_0013, 3, 1'b1);
    hit(32'h0000_0000, 32'h0000_0013);
    // Byte offset bits are ignored.
    hit(32'h0000_0003, 32'h0000_0013);

    // Conflict eviction on index 1.
    miss_fill(32'h0000_0004, 32'hAAAA_0004, 1, 1'b1);
    hit(32'h0000_0004, 32'hAAAA_0004);
    miss_fill(32'h0000_0404, 32'hBBBB_0404, 2, 1'b1);
    hit(32'h0000_0404, 32'hBBBB_0404);
    miss_fill(32'h0000_0004, 32'hCCCC_0004, 1, 1'b1);

    // Held request: pulses only on alternate cycles.
    IF_inst_read_valid = 1'b1;
    IF_inst_addr = 32'h0000_0004;
    pattern = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      tick();
      pattern[i] = IF_inst_valid;
      check("held_nomem", {31'd0, MemCtrl_read_valid}, 32'd0);
    end
    check("held_pattern", {26'd0, pattern}, 32'h0000_0015);
    check("held_data", IF_inst, 32'hCCCC_0004);
    IF_inst_read_valid = 1'b0;
    tick();

    // clear in IDLE blocks sampling.
    IF_inst_read_valid = 1'b1;
    clear = 1'b1;
    tick();
    check("clear_idle_noresp", {31'd0, IF_inst_valid}, 32'd0);
    check("clear_idle_nomem", {31'd0, MemCtrl_read_valid}, 32'd0);
    clear = 1'b0;
    IF_inst_read_valid = 1'b0;

    // clear one cycle before the fill: line written, response suppressed.
    IF_inst_read_valid = 1'b1;
    IF_inst_addr = 32'h0000_0100;
    tick();
    check("kill_miss_req", {31'd0, MemCtrl_read_valid}, 32'd1);
    IF_inst_read_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("kill_still_req", {31'd0, MemCtrl_read_valid}, 32'd1);
    MemCtrl_inst_valid = 1'b1;
    MemCtrl_inst = 32'h5555_0100;
    tick();
    MemCtrl_inst_valid = 1'b0;
    check("kill_noresp", {31'd0, IF_inst_valid}, 32'd0);
    check("kill_req_drop", {31'd0, MemCtrl_read_valid}, 32'd0);
    tick();
    hit(32'h0000_0100, 32'h5555_0100);
    // After the killed fill, a normal miss responds again.
    miss_fill(32'h0000_0108, 32'h0000_0108, 1, 1'b1);

    // clear in the same cycle as the fill data.
    IF_inst_read_valid = 1'b1;
    IF_inst_addr = 32'h0000_0200;
    tick();
    IF_inst_read_valid = 1'b0;
    clear = 1'b1;
    MemCtrl_inst_valid = 1'b1;
    MemCtrl_inst = 32'h6666_0200;
    tick();
    clear = 1'b0;
    MemCtrl_inst_valid = 1'b0;
    check("clr_fill_noresp", {31'd0, IF_inst_valid}, 32'd0);
    check("clr_fill_req_drop", {31'd0, MemCtrl_read_valid}, 32'd0);
    tick();
    hit(32'h0000_0200, 32'h6666_0200);

    // rdy low in MISS_WAIT freezes outputs, including against a fill pulse.
    IF_inst_read_valid = 1'b1;
    IF_inst_addr = 32'h0000_0300;
    tick();
    IF_inst_read_valid = 1'b0;
    rdy = 1'b0;
    MemCtrl_inst_valid = 1'b1;
    MemCtrl_inst = 32'h7777_0300;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("frz_req", {31'd0, MemCtrl_read_valid}, 32'd1);
      check("frz_addr", MemCtrl_addr, 32'h0000_0300);
      check("frz_noresp", {31'd0, IF_inst_valid}, 32'd0);
    end
    MemCtrl_inst_valid = 1'b0;
    rst = 1'b1;
    rdy = 1'b1;
    tick();
    check("rst2_req", {31'd0, MemCtrl_read_valid}, 32'd0);
    check("rst2_addr", MemCtrl_addr, 32'd0);
    rst = 1'b0;
    tick();
    // All lines invalid after reset.
    miss_fill(32'h0000_0000, 32'h0000_0099, 1, 1'b1);
    miss_fill(32'h0000_0004, 32'h0000_0098, 1, 1'b1);
    hit(32'h0000_0000, 32'h0000_0099);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
